// File: rtl/getir.sv
// Instruction fetch stage: owns the program counter, drives the L1 I-cache address
// and holds one fetched instruction for decode, with redirect and perf counters.
module getir #(
  parameter logic [31:0] RESET_ADRES = 32'h4000_0000,
  parameter logic [31:0] NOP_BUYRUK  = 32'h0000_0013
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic [31:0] l1b_adres_o,
  input  logic        l1b_bekle_i,
  input  logic [31:0] l1b_deger_i,
  input  logic        yonlendir_gecerli_i,
  input  logic [31:0] yonlendir_adres_i,
  input  logic        coz_durdur_i,
  output logic        coz_gecerli_o,
  output logic [31:0] coz_buyruk_o,
  output logic [31:0] coz_ps_o,
  output logic [31:0] getirilen_sayisi_o,
  output logic [31:0] bekleme_sayisi_o
);

  logic [31:0] r_ps;
  logic        r_gecerli;
  logic [31:0] r_buyruk;
  logic [31:0] r_coz_ps;
  logic [31:0] r_getirilen;
  logic [31:0] r_bekleme;

  logic w_bos;
  logic w_kabul;
  logic w_tuketildi;

  // Output slot is free when empty or when decode takes the held instruction.
  assign w_bos       = ~r_gecerli | ~coz_durdur_i;
  assign w_kabul     = ~yonlendir_gecerli_i & ~l1b_bekle_i & w_bos;
  assign w_tuketildi = r_gecerli & ~coz_durdur_i & l1b_bekle_i;

  // PC, output register and counters; redirect beats accept beats drain.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_ps        <= RESET_ADRES;
      r_gecerli   <= 1'b0;
      r_buyruk    <= NOP_BUYRUK;
      r_coz_ps    <= 32'h0000_0000;
      r_getirilen <= 32'h0000_0000;
      r_bekleme   <= 32'h0000_0000;
    end else begin
      if (yonlendir_gecerli_i) begin
        r_ps      <= {yonlendir_adres_i[31:2], 2'b00};
        r_gecerli <= 1'b0;
        r_buyruk  <= NOP_BUYRUK;
      end else if (w_kabul) begin
        r_gecerli   <= 1'b1;
        r_buyruk    <= l1b_deger_i;
        r_coz_ps    <= r_ps;
        r_ps        <= r_ps + 32'd4;
        r_getirilen <= r_getirilen + 32'd1;
      end else if (w_tuketildi) begin
        r_gecerli <= 1'b0;
        r_buyruk  <= NOP_BUYRUK;
      end else begin
        r_ps      <= r_ps;
        r_gecerli <= r_gecerli;
      end
      // Miss cycles count only when no redirect is abandoning the lookup.
      if (l1b_bekle_i && !yonlendir_gecerli_i) begin
        r_bekleme <= r_bekleme + 32'd1;
      end else begin
        r_bekleme <= r_bekleme;
      end
    end
  end

  assign l1b_adres_o        = r_ps;
  assign coz_gecerli_o      = r_gecerli;
  assign coz_buyruk_o       = r_buyruk;
  assign coz_ps_o           = r_coz_ps;
  assign getirilen_sayisi_o = r_getirilen;
  assign bekleme_sayisi_o   = r_bekleme;

endmodule

// File: tb/tb_getir.sv
// Randomized and directed bench for getir, checked every cycle against a
// behavioural fetch model plus hand-computed literal expectations.
module tb_getir;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic [31:0] l1b_adres_o;
  logic        l1b_bekle_i;
  logic [31:0] l1b_deger_i;
  logic        yonlendir_gecerli_i;
  logic [31:0] yonlendir_adres_i;
  logic        coz_durdur_i;
  logic        coz_gecerli_o;
  logic [31:0] coz_buyruk_o;
  logic [31:0] coz_ps_o;
  logic [31:0] getirilen_sayisi_o;
  logic [31:0] bekleme_sayisi_o;

  getir dut (
    .clk_i(clk_i), .rst_i(rst_i),
    .l1b_adres_o(l1b_adres_o), .l1b_bekle_i(l1b_bekle_i), .l1b_deger_i(l1b_deger_i),
    .yonlendir_gecerli_i(yonlendir_gecerli_i), .yonlendir_adres_i(yonlendir_adres_i),
    .coz_durdur_i(coz_durdur_i), .coz_gecerli_o(coz_gecerli_o),
    .coz_buyruk_o(coz_buyruk_o), .coz_ps_o(coz_ps_o),
    .getirilen_sayisi_o(getirilen_sayisi_o), .bekleme_sayisi_o(bekleme_sayisi_o)
  );

  always #5 clk_i = ~clk_i;

  int n_checks = 0;
  int n_err    = 0;
  bit chk_en   = 1'b0;

  // Behavioural model state
  logic [31:0] m_ps, m_instr, m_cps, m_fetched, m_stalls;
  bit          m_valid;

  // Instruction memory contents as seen by the fetch address.
  function automatic logic [31:0] imem(input logic [31:0] a);
    return {a[15:0], ~a[31:16]} ^ 32'h1357_9BDF;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
    end
  endtask

  // Advance the model by one clock using the inputs applied for that edge.
  task automatic model_step();
    if (rst_i) begin
      m_ps = 32'h4000_0000; m_valid = 0; m_instr = 32'h13; m_cps = 0;
      m_fetched = 0; m_stalls = 0;
    end else begin
      if (l1b_bekle_i && !yonlendir_gecerli_i) m_stalls++;
      if (yonlendir_gecerli_i) begin
        m_ps = yonlendir_adres_i & 32'hFFFF_FFFC;
        m_valid = 0; m_instr = 32'h13;
      end else if (!l1b_bekle_i && (!m_valid || !coz_durdur_i)) begin
        m_valid = 1; m_instr = imem(m_ps); m_cps = m_ps;
        m_ps = m_ps + 4; m_fetched++;
      end else if (m_valid && !coz_durdur_i) begin
        m_valid = 0; m_instr = 32'h13;
      end
    end
  endtask

  // Per-cycle comparison of every output against the model.
  always @(negedge clk_i) begin
    if (chk_en) begin
      chk("adres", l1b_adres_o, m_ps);
      chk("gecerli", {31'd0, coz_gecerli_o}, {31'd0, m_valid});
      chk("buyruk", coz_buyruk_o, m_instr);
      chk("coz_ps", coz_ps_o, m_cps);
      chk("getirilen", getirilen_sayisi_o, m_fetched);
      chk("bekleme", bekleme_sayisi_o, m_stalls);
    end
  end

  // Apply one cycle of stimulus, clock it, and return after the falling edge.
  task automatic cyc(input bit rst, input bit bekle, input bit yon,
                     input logic [31:0] yadr, input bit durdur);
    rst_i = rst; l1b_bekle_i = bekle; yonlendir_gecerli_i = yon;
    yonlendir_adres_i = yadr; coz_durdur_i = durdur;
    l1b_deger_i = bekle ? $urandom : imem(l1b_adres_o);
    @(posedge clk_i);
    model_step();
    @(negedge clk_i);
    #1;
  endtask

  logic [31:0] saved;

  initial begin
    rst_i = 1; l1b_bekle_i = 1; yonlendir_gecerli_i = 0; yonlendir_adres_i = 0;
    coz_durdur_i = 0; l1b_deger_i = 0;
    @(negedge clk_i);
    cyc(1, 1, 0, 0, 0);
    cyc(1, 0, 1, 32'h1234_5678, 0);
    chk_en = 1;
    chk("rst_adres", l1b_adres_o, 32'h4000_0000);
    chk("rst_buyruk", coz_buyruk_o, 32'h0000_0013);
    chk("rst_coz_ps", coz_ps_o, 32'h0);
    chk("rst_gecerli", {31'd0, coz_gecerli_o}, 32'h0);

    // Post-reset cache initialisation stall
    for (int i = 0; i < 515; i++) cyc(0, 1, 0, 0, 0);
    chk("stall_adres", l1b_adres_o, 32'h4000_0000);
    chk("stall_cnt", bekleme_sayisi_o, 32'd515);
    cyc(0, 0, 0, 0, 0); chk("ps0", coz_ps_o, 32'h4000_0000);
    cyc(0, 0, 0, 0, 0); chk("ps1", coz_ps_o, 32'h4000_0004);
    cyc(0, 0, 0, 0, 0); chk("ps2", coz_ps_o, 32'h4000_0008);
    chk("fetch3", getirilen_sayisi_o, 32'd3);

    // Decode stall holds everything even with cache hits available
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1);
    chk("hold_ps", coz_ps_o, 32'h4000_0008);
    chk("hold_adres", l1b_adres_o, 32'h4000_000C);
    cyc(0, 0, 0, 0, 0);
    chk("release_ps", coz_ps_o, 32'h4000_000C);

    // Redirect squashes a stalled valid instruction
    cyc(0, 1, 1, 32'h4000_0103, 1);
    chk("redir_gecerli", {31'd0, coz_gecerli_o}, 32'h0);
    chk("redir_buyruk", coz_buyruk_o, 32'h0000_0013);
    chk("redir_adres", l1b_adres_o, 32'h4000_0100);
    cyc(0, 0, 0, 0, 0);
    chk("redir_first", coz_ps_o, 32'h4000_0100);

    // Redirect wins over a coincident hit
    saved = getirilen_sayisi_o;
    cyc(0, 0, 1, 32'h4000_0200, 0);
    chk("redir_hit_cnt", getirilen_sayisi_o, saved);
    chk("redir_hit_adres", l1b_adres_o, 32'h4000_0200);

    // PC wrap at the top of the address space
    cyc(0, 0, 1, 32'hFFFF_FFFE, 0);
    cyc(0, 0, 0, 0, 0); chk("wrap0", coz_ps_o, 32'hFFFF_FFFC);
    cyc(0, 0, 0, 0, 0); chk("wrap1", coz_ps_o, 32'h0000_0000);

    // Reset mid-miss with a valid instruction held
    cyc(0, 1, 0, 0, 1);
    cyc(1, 1, 0, 0, 1);
    chk("rst2_gecerli", {31'd0, coz_gecerli_o}, 32'h0);
    chk("rst2_adres", l1b_adres_o, 32'h4000_0000);
    chk("rst2_fetch", getirilen_sayisi_o, 32'h0);
    chk("rst2_stall", bekleme_sayisi_o, 32'h0);

    // Random traffic
    for (int i = 0; i < 4000; i++) begin
      cyc(($urandom_range(0, 199) == 0),
          ($urandom_range(0, 2) == 0),
          ($urandom_range(0, 9) == 0),
          $urandom,
          ($urandom_range(0, 3) == 0));
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule

// File: doc/getir.md
Name: getir

Overview:
- Instruction fetch stage that sits directly upstream of the L1 instruction cache.
- Owns the program counter (PS) and drives the cache lookup address.
- Captures returned instructions into a one-entry output register that feeds the decode stage (coz).
- Applies branch/jump redirects from execute and counts fetched instructions and cache stall cycles for performance monitoring.

Parameters:
- RESET_ADRES, 32'h4000_0000, PS value loaded on reset; bits [1:0] must be 0.
- NOP_BUYRUK, 32'h0000_0013, value driven on coz_buyruk_o when no valid instruction is held (addi x0,x0,0).

Ports:
- clk_i  input  1  clock, all state updates on rising edge
- rst_i  input  1  synchronous, active-high reset
- l1b_adres_o  output  32  fetch address to the instruction cache; equals the PS register
- l1b_bekle_i  input  1  cache stall; 0 means l1b_deger_i is the instruction at l1b_adres_o this cycle
- l1b_deger_i  input  32  instruction word from the cache
- yonlendir_gecerli_i  input  1  redirect request from execute (taken branch, jump, trap)
- yonlendir_adres_i  input  32  redirect target; bits [1:0] are ignored
- coz_durdur_i  input  1  decode cannot accept this cycle
- coz_gecerli_o  output  1  output register holds a valid instruction
- coz_buyruk_o  output  32  instruction to decode
- coz_ps_o  output  32  address of coz_buyruk_o
- getirilen_sayisi_o  output  32  count of instructions accepted from the cache
- bekleme_sayisi_o  output  32  count of cycles with l1b_bekle_i=1 while no redirect is pending

Behaviour:
- Reset (rst_i=1 at a clock edge, any state, including mid-stall):
  - ps <= RESET_ADRES
  - coz_gecerli_o <= 0, coz_buyruk_o <= NOP_BUYRUK, coz_ps_o <= 0
  - both counters <= 0
- l1b_adres_o is driven straight from the ps register, with no combinational path from any input.
- The cache compares against the address it is currently given, so ps holds stable in every cycle that is not an accept or a redirect.
- bos ("slot free") = ~coz_gecerli_o | ~coz_durdur_i.
- kabul (accept) = ~yonlendir_gecerli_i & ~l1b_bekle_i & bos.
- Priority per cycle, highest first:
  1. Redirect (yonlendir_gecerli_i=1):
     - ps <= {yonlendir_adres_i[31:2], 2'b00}
     - coz_gecerli_o <= 0, coz_buyruk_o <= NOP_BUYRUK; the held instruction is squashed even if coz_durdur_i=1
     - l1b_deger_i is discarded even if l1b_bekle_i=0
     - an in-progress cache miss is abandoned; the cache sees the new address next cycle
  2. Accept (kabul=1):
     - coz_gecerli_o <= 1, coz_buyruk_o <= l1b_deger_i, coz_ps_o <= ps
     - ps <= ps + 4 (mod 2^32; 32'hFFFF_FFFC wraps to 0)
     - getirilen_sayisi_o increments
  3. Decode consumed, no new instruction (coz_gecerli_o=1, coz_durdur_i=0, l1b_bekle_i=1):
     - coz_gecerli_o <= 0, coz_buyruk_o <= NOP_BUYRUK
     - ps holds
  4. Otherwise: all state holds.
     - This covers decode stalled with a valid instruction; the cache output is ignored and ps is not advanced even when l1b_bekle_i=0.
- bekleme_sayisi_o increments in any cycle with l1b_bekle_i=1 and yonlendir_gecerli_i=0, including the cache's post-reset initialisation period.
- Counters wrap at 2^32 with no saturation.
- Throughput is one instruction per cycle on back-to-back hits with coz_durdur_i=0.
- Latency: an instruction accepted at edge N is visible on coz_* after edge N.
- Back-to-back redirects: the last one wins.
- A redirect in the same cycle as a hit: the redirect wins and the counter does not increment.

Test Plan:
- Reset release, l1b_bekle_i=1 for 515 cycles, then held 0 → l1b_adres_o=4000_0000 throughout the stall; bekleme_sayisi_o=515; coz_ps_o sequence 4000_0000, 4000_0004, 4000_0008 on consecutive cycles; getirilen_sayisi_o=3 after 3 cycles.
- Hits streaming, then coz_durdur_i=1 for 4 cycles with coz_ps_o=4000_0008 → coz_* hold 4000_0008; l1b_adres_o holds 4000_000C; on release, 4000_000C follows in the next cycle.
- Redirect to 32'h4000_0103 while coz_gecerli_o=1 and coz_durdur_i=1 → next cycle coz_gecerli_o=0, coz_buyruk_o=0000_0013, l1b_adres_o=4000_0100; first output after the hit has coz_ps_o=4000_0100.
- Redirect coincident with l1b_bekle_i=0 and bos=1 → instruction discarded; getirilen_sayisi_o unchanged; ps = target.
- Redirect to FFFF_FFFC, then two hits → coz_ps_o FFFF_FFFC then 0000_0000.
- rst_i asserted mid-miss with coz_gecerli_o=1 → next cycle all outputs at reset values; counters 0.
